// File: rtl/clock_monitor_if.sv
// clock_monitor_if: measurement and status results of the clock monitor
interface clock_monitor_if #(parameter int W = 16);
  logic [W-1:0] HIGH_CNT, LOW_CNT;
  logic [W:0] PERIOD;
  logic VLD, ERR, LOCK, STALL;
  logic [31:0] NCYC;
  modport master(output HIGH_CNT, LOW_CNT, PERIOD, VLD, ERR, LOCK, STALL, NCYC);
  modport slave(input HIGH_CNT, LOW_CNT, PERIOD, VLD, ERR, LOCK, STALL, NCYC);
endinterface

// File: rtl/clock_monitor.sv
// clock_monitor: measures high/low/period of an asynchronous clock in CLK cycles and reports error, lock and stall
module clock_monitor #(
  parameter int W = 16,
  parameter int SYNC = 2,
  parameter int EXP_HIGH = 5,
  parameter int EXP_LOW = 5,
  parameter int TOL = 1,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT = 1000
) (
  input logic CLK,
  input logic RST,
  input logic EN,
  input logic MON_CLK,
  clock_monitor_if.master mon
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [SYNC-1:0] sync;
  logic s, s_d, rise, fall, load, bad, hit;
  logic [W-1:0] hcnt, lcnt, hcnt_n, lcnt_n;
  logic [W:0] h, l;
  logic [GW-1:0] good, good_n;
  logic [IW-1:0] idle;
  assign s = sync[SYNC-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
  assign h = {1'b0, hcnt};
  assign l = {1'b0, lcnt};
  assign load = EN && state == LOW && rise;
  assign hit = EN && !rise && !fall && idle == IW'(TIMEOUT - 1);
  assign bad = h > (W+1)'(EXP_HIGH + TOL) || h + (W+1)'(TOL) < (W+1)'(EXP_HIGH) ||
               l > (W+1)'(EXP_LOW + TOL) || l + (W+1)'(TOL) < (W+1)'(EXP_LOW);
  assign good_n = (!EN || hit || (load && bad)) ? '0 :
                  (load && good != GW'(LOCK_CNT)) ? good + 1'b1 : good;
  always_comb begin
    state_n = state;
    hcnt_n = hcnt;
    lcnt_n = lcnt;
    if (!EN) begin
      state_n = IDLE;
      hcnt_n = '0;
      lcnt_n = '0;
    end else if (hit) state_n = IDLE;
    else
      case (state)
        IDLE: if (rise) begin
          state_n = HIGH;
          hcnt_n = W'(1);
        end
        HIGH: if (fall) begin
          state_n = LOW;
          lcnt_n = W'(1);
        end else hcnt_n = hcnt + W'(hcnt != '1);
        LOW: if (rise) begin
          state_n = HIGH;
          hcnt_n = W'(1);
        end else lcnt_n = lcnt + W'(lcnt != '1);
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      sync <= '0;
      s_d <= 1'b0;
      state <= IDLE;
      hcnt <= '0;
      lcnt <= '0;
      good <= '0;
      idle <= '0;
      mon.HIGH_CNT <= '0;
      mon.LOW_CNT <= '0;
      mon.PERIOD <= '0;
      mon.VLD <= 1'b0;
      mon.ERR <= 1'b0;
      mon.LOCK <= 1'b0;
      mon.STALL <= 1'b0;
      mon.NCYC <= '0;
    end else begin
      sync <= {sync[SYNC-2:0], MON_CLK};
      s_d <= s;
      state <= state_n;
      hcnt <= hcnt_n;
      lcnt <= lcnt_n;
      good <= good_n;
      idle <= (!EN || rise || fall) ? '0 : idle == IW'(TIMEOUT) ? idle : idle + 1'b1;
      mon.VLD <= load;
      mon.ERR <= load && bad;
      mon.LOCK <= good_n == GW'(LOCK_CNT);
      // a rise in the timeout cycle wins, so no stall is flagged then
      mon.STALL <= (!EN || rise) ? 1'b0 : hit ? 1'b1 : mon.STALL;
      if (load) begin
        mon.HIGH_CNT <= hcnt;
        mon.LOW_CNT <= lcnt;
        mon.PERIOD <= h + l;
        mon.NCYC <= mon.NCYC + 1'b1;
      end
    end
endmodule
